// File: rtl/vga_timing_recovery.sv
// vga_timing_recovery: rebuilds hcount/vcount from sync/blank inputs
// and declares lock once line and frame geometry match the timing.
module vga_timing_recovery #(
   parameter int H_TOTAL      = 1344,
   parameter int V_TOTAL      = 806,
   parameter int H_SYNC_START = 1048,
   parameter int V_SYNC_START = 771
) (
   input  logic        clk65MHz,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic        locked,
   output logic        sync_err,
   output logic [10:0] line_len,
   output logic [10:0] frame_lines
);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   localparam logic [10:0] CMAX = 11'h7ff;
   localparam logic [10:0] HT   = 11'(H_TOTAL);
   localparam logic [10:0] VT   = 11'(V_TOTAL);
   localparam logic [10:0] HS   = 11'(H_SYNC_START);
   localparam logic [10:0] VS   = 11'(V_SYNC_START);

   logic [1:0]  state;
   logic        vpend;
   logic        line_bad;
   logic        hfall;
   logic        vfall;
   logic        hsrise;
   logic        vsrise;
   logic        frame_start;
   logic [10:0] hinc;
   logic [10:0] vinc;
   logic [10:0] p;
   logic [10:0] v;
   logic        err;
   logic        meas_ok;

   // The delayed sync/blank outputs double as previous-cycle copies.
   always_comb begin
      hfall       = hblnk_out & ~hblnk_in;
      vfall       = vblnk_out & ~vblnk_in;
      hsrise      = ~hsync_out & hsync_in;
      vsrise      = ~vsync_out & vsync_in;
      frame_start = hfall & (vfall | vpend);
      hinc = (hcount_out == CMAX) ? CMAX : hcount_out + 11'd1;
      vinc = (vcount_out == CMAX) ? CMAX : vcount_out + 11'd1;
      p    = hfall ? 11'd0 : hinc;
      if (frame_start)
         v = 11'd0;
      else if (hfall)
         v = vinc;
      else
         v = vcount_out;
      err = (hfall && hinc != HT)
         || (!hfall && p == HT)
         || (frame_start && vinc != VT)
         || (!frame_start && v == VT)
         || (hsrise && p != HS)
         || (vsrise && (p != 11'd0 || v != VS));
      meas_ok = frame_start && !line_bad
         && hinc == HT && vinc == VT;
   end

   // Counters, delayed timing copies and measurements.
   always_ff @(posedge clk65MHz or posedge rst) begin
      if (rst) begin
         hcount_out  <= '0;
         vcount_out  <= '0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         hblnk_out   <= 1'b0;
         vblnk_out   <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
         vpend       <= 1'b0;
         line_bad    <= 1'b0;
      end else begin
         hcount_out <= p;
         vcount_out <= v;
         hsync_out  <= hsync_in;
         vsync_out  <= vsync_in;
         hblnk_out  <= hblnk_in;
         vblnk_out  <= vblnk_in;
         if (hfall)
            line_len <= hinc;
         if (frame_start)
            frame_lines <= vinc;
         if (hfall)
            vpend <= 1'b0;
         else if (vfall)
            vpend <= 1'b1;
         if (frame_start)
            line_bad <= 1'b0;
         else if (hfall && hinc != HT)
            line_bad <= 1'b1;
      end
   end

   // Lock FSM: search a frame start, measure one frame, then police.
   always_ff @(posedge clk65MHz or posedge rst) begin
      if (rst) begin
         state    <= SEARCH;
         locked   <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         case (state)
            SEARCH: begin
               if (frame_start)
                  state <= MEASURE;
            end
            MEASURE: begin
               if (meas_ok) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
            LOCKED: begin
               if (err) begin
                  state    <= SEARCH;
                  locked   <= 1'b0;
                  sync_err <= 1'b1;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_timing_recovery.sv
// tb_vga_timing_recovery: directed bench with a scaled-down
// timing generator driving the recovery block.
module tb_vga_timing_recovery;

   localparam int H_T   = 64;
   localparam int H_ACT = 48;
   localparam int HS    = 52;
   localparam int HS_W  = 8;
   localparam int V_T   = 24;
   localparam int V_ACT = 18;
   localparam int VS    = 20;
   localparam int VS_W  = 2;
   localparam int FRAME = H_T * V_T;

   logic        clk65MHz = 1'b0;
   logic        rst = 1'b1;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic        hblnk_in = 1'b0;
   logic        vblnk_in = 1'b0;
   logic [10:0] hcount_out;
   logic [10:0] vcount_out;
   logic        hsync_out;
   logic        vsync_out;
   logic        hblnk_out;
   logic        vblnk_out;
   logic        locked;
   logic        sync_err;
   logic [10:0] line_len;
   logic [10:0] frame_lines;

   int tests = 0;
   int fails = 0;
   int gh = 0;
   int gv = 0;
   int ph = 0;
   int pv = 0;
   int vtot = V_T;
   bit sup_hblnk = 1'b0;
   bit dly_hsync = 1'b0;
   bit err_seen = 1'b0;

   vga_timing_recovery #(
      .H_TOTAL(H_T),
      .V_TOTAL(V_T),
      .H_SYNC_START(HS),
      .V_SYNC_START(VS)
   ) dut (
      .clk65MHz(clk65MHz),
      .rst(rst),
      .hsync_in(hsync_in),
      .vsync_in(vsync_in),
      .hblnk_in(hblnk_in),
      .vblnk_in(vblnk_in),
      .hcount_out(hcount_out),
      .vcount_out(vcount_out),
      .hsync_out(hsync_out),
      .vsync_out(vsync_out),
      .hblnk_out(hblnk_out),
      .vblnk_out(vblnk_out),
      .locked(locked),
      .sync_err(sync_err),
      .line_len(line_len),
      .frame_lines(frame_lines)
   );

   always #5 clk65MHz = ~clk65MHz;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic logic [49:0] outs();
      return {hcount_out, vcount_out, line_len, frame_lines,
              hsync_out, vsync_out, hblnk_out, vblnk_out,
              locked, sync_err};
   endfunction

   task automatic step();
      hblnk_in = (gh >= H_ACT) && !sup_hblnk;
      if (dly_hsync)
         hsync_in = (gh > HS) && (gh <= HS + HS_W);
      else
         hsync_in = (gh >= HS) && (gh < HS + HS_W);
      vblnk_in = (gv >= V_ACT);
      vsync_in = (gv >= VS) && (gv < VS + VS_W);
      ph = gh;
      pv = gv;
      gh++;
      if (gh == H_T) begin
         gh = 0;
         gv++;
         if (gv >= vtot)
            gv = 0;
      end
      @(posedge clk65MHz);
      #1;
      if (sync_err === 1'b1)
         err_seen = 1'b1;
   endtask

   task automatic run_to(input int h, input int v);
      while (!(gh == h && gv == v))
         step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'(i * 5 + 3);
         @(posedge clk65MHz);
         #1;
         tests++;
         if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_hold %0d: got %h want 0", i, outs());
         end
      end
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0;
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if (outs() !== '0) begin
         fails++;
         $display("FAIL reset_release: got %h want 0", outs());
      end
      gh = 0;
      gv = 0;
      step();
      tests++;
      if (hcount_out !== 11'd1 || outs() !== {11'd1, 39'd0}) begin
         fails++;
         $display("FAIL first_edge: got %h want hcount 1, rest 0",
                  outs());
      end
   endtask

   task automatic test_ideal();
      int fs = 0;
      bit synced = 1'b0;
      logic [3:0] fl;
      logic exp_l;
      for (int n = 0; n < 3 * FRAME; n++) begin
         step();
         if (ph == 0 && pv == 0)
            fs++;
         if (ph == 0 && pv == 1)
            synced = 1'b1;
         fl = {(ph >= HS) && (ph < HS + HS_W),
               (pv >= VS) && (pv < VS + VS_W),
               ph >= H_ACT, pv >= V_ACT};
         exp_l = (fs >= 2);
         if (synced) begin
            tests++;
            if (hcount_out !== 11'(ph) || vcount_out !== 11'(pv)) begin
               fails++;
               $display("FAIL ideal_count: got %0d,%0d want %0d,%0d",
                        hcount_out, vcount_out, ph, pv);
            end
         end
         tests++;
         if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== fl) begin
            fails++;
            $display("FAIL ideal_flags at %0d,%0d: got %b want %b",
                     ph, pv,
                     {hsync_out, vsync_out, hblnk_out, vblnk_out}, fl);
         end
         tests++;
         if (locked !== exp_l || sync_err !== 1'b0) begin
            fails++;
            $display("FAIL ideal_lock at %0d,%0d: got l=%b e=%b want l=%b e=0",
                     ph, pv, locked, sync_err, exp_l);
         end
      end
      tests++;
      if (line_len !== 11'(H_T)) begin
         fails++;
         $display("FAIL line_len: got %0d want %0d", line_len, H_T);
      end
      tests++;
      if (frame_lines !== 11'(V_T)) begin
         fails++;
         $display("FAIL frame_lines: got %0d want %0d", frame_lines, V_T);
      end
   endtask

   task automatic test_missing_hblnk();
      err_seen = 1'b0;
      run_to(H_ACT, 5);
      sup_hblnk = 1'b1;
      run_to(0, 6);
      sup_hblnk = 1'b0;
      tests++;
      if (err_seen || locked !== 1'b1) begin
         fails++;
         $display("FAIL miss_pre: got e=%b l=%b want e=0 l=1",
                  err_seen, locked);
      end
      step();
      tests++;
      if (sync_err !== 1'b1 || locked !== 1'b0
          || hcount_out !== 11'(H_T)) begin
         fails++;
         $display("FAIL miss_err: got e=%b l=%b h=%0d want e=1 l=0 h=%0d",
                  sync_err, locked, hcount_out, H_T);
      end
      step();
      tests++;
      if (sync_err !== 1'b0) begin
         fails++;
         $display("FAIL miss_pulse: got %b want 0", sync_err);
      end
      err_seen = 1'b0;
      run_to(0, 0);
      step();
      tests++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL miss_fs1: got %b want 0", locked);
      end
      run_to(0, 0);
      tests++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL miss_prelock: got %b want 0", locked);
      end
      step();
      tests++;
      if (locked !== 1'b1 || err_seen) begin
         fails++;
         $display("FAIL miss_relock: got l=%b e=%b want l=1 e=0",
                  locked, err_seen);
      end
   endtask

   task automatic test_hsync_delay();
      err_seen = 1'b0;
      run_to(0, 3);
      dly_hsync = 1'b1;
      run_to(HS + 1, 3);
      tests++;
      if (err_seen || locked !== 1'b1) begin
         fails++;
         $display("FAIL hs_pre: got e=%b l=%b want e=0 l=1",
                  err_seen, locked);
      end
      step();
      tests++;
      if (sync_err !== 1'b1 || locked !== 1'b0) begin
         fails++;
         $display("FAIL hs_err: got e=%b l=%b want e=1 l=0",
                  sync_err, locked);
      end
      run_to(0, 4);
      dly_hsync = 1'b0;
      tests++;
      if (sync_err !== 1'b0) begin
         fails++;
         $display("FAIL hs_pulse: got %b want 0", sync_err);
      end
   endtask

   task automatic test_short_frame();
      run_to(0, 0);
      step();
      tests++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL short_enter: got %b want 0", locked);
      end
      vtot = V_T - 1;
      run_to(0, 0);
      vtot = V_T;
      step();
      tests++;
      if (frame_lines !== 11'(V_T - 1) || locked !== 1'b0) begin
         fails++;
         $display("FAIL short_frame: got fl=%0d l=%b want fl=%0d l=0",
                  frame_lines, locked, V_T - 1);
      end
      run_to(0, 0);
      step();
      tests++;
      if (frame_lines !== 11'(V_T) || locked !== 1'b1) begin
         fails++;
         $display("FAIL short_relock: got fl=%0d l=%b want fl=%0d l=1",
                  frame_lines, locked, V_T);
      end
   endtask

   task automatic test_async_reset();
      run_to(20, 10);
      tests++;
      if (locked !== 1'b1) begin
         fails++;
         $display("FAIL ar_pre: got %b want 1", locked);
      end
      #3;
      rst = 1'b1;
      #1;
      tests++;
      if (outs() !== '0) begin
         fails++;
         $display("FAIL ar_clear: got %h want 0", outs());
      end
      step();
      tests++;
      if (outs() !== '0) begin
         fails++;
         $display("FAIL ar_hold: got %h want 0", outs());
      end
      rst = 1'b0;
      run_to(1, 11);
      tests++;
      if (hcount_out !== 11'd0 || locked !== 1'b0) begin
         fails++;
         $display("FAIL ar_resync: got h=%0d l=%b want h=0 l=0",
                  hcount_out, locked);
      end
      step();
      tests++;
      if (hcount_out !== 11'd1) begin
         fails++;
         $display("FAIL ar_count: got %0d want 1", hcount_out);
      end
      run_to(0, 0);
      step();
      tests++;
      if (locked !== 1'b0) begin
         fails++;
         $display("FAIL ar_fs1: got %b want 0", locked);
      end
      run_to(0, 0);
      step();
      tests++;
      if (locked !== 1'b1 || hcount_out !== 11'd0
          || vcount_out !== 11'd0) begin
         fails++;
         $display("FAIL ar_relock: got l=%b h=%0d v=%0d want 1,0,0",
                  locked, hcount_out, vcount_out);
      end
   endtask

   task automatic test_saturation();
      err_seen = 1'b0;
      sup_hblnk = 1'b1;
      for (int i = 0; i < 2100; i++)
         step();
      while (gh != 0)
         step();
      tests++;
      if (hcount_out !== 11'h7ff || !err_seen || locked !== 1'b0) begin
         fails++;
         $display("FAIL sat_hold: got h=%0d e=%b l=%b want 2047 1 0",
                  hcount_out, err_seen, locked);
      end
      sup_hblnk = 1'b0;
      do step(); while (gh != 0);
      step();
      tests++;
      if (hcount_out !== 11'd0 || line_len !== 11'h7ff) begin
         fails++;
         $display("FAIL sat_len: got h=%0d len=%0d want 0 2047",
                  hcount_out, line_len);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_missing_hblnk();
      test_hsync_delay();
      test_short_frame();
      test_async_reset();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
